// File: rtl/fifo_port_arbiter.sv
// Shares the single port of a fall-through syncFIFO between NUM_REQ round-robin
// writers and one reader; reads and writes alternate when both are eligible.

module fifo_port_arbiter_lane #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_sel,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_grant,
  output logic [DATA_WIDTH-1:0] o_data
);
  assign o_grant = i_sel;
  assign o_data  = i_sel ? i_data : '0;
endmodule

module fifo_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int SIZE       = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_wr_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_REQ-1:0]            o_wr_grant,
  input  logic                          i_rd_req,
  output logic                          o_rd_grant,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic                          o_rd_valid,
  output logic                          o_fifo_en,
  output logic                          o_fifo_rw,
  output logic [$clog2(SIZE)-1:0]       o_fifo_addr,
  output logic [DATA_WIDTH-1:0]         o_fifo_in,
  input  logic [DATA_WIDTH-1:0]         i_fifo_out,
  input  logic                          i_fifo_empty,
  input  logic                          i_fifo_full,
  output logic [$clog2(SIZE):0]         o_count
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

  op_e                 r_last_op;
  logic [PW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_count;
  logic                r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                w_ok, r_ok, w_do_wr, w_do_rd;
  logic                w_found;
  logic [PW-1:0]       w_sel;
  logic [PW:0]         w_idx;
  logic [2*NUM_REQ-1:0] w_vv;
  logic [NUM_REQ-1:0]  w_lane_sel;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_lane_data;
  logic [DATA_WIDTH-1:0] w_fifo_in;

  // Occupancy guards the FIFO flags so a flag glitch can never over/underflow.
  assign w_ok = (|i_wr_valid) && !i_fifo_full && (r_count != CW'(SIZE));
  assign r_ok = i_rd_req && !i_fifo_empty && (r_count != '0);

  assign w_do_wr = !i_rst && w_ok && (!r_ok || r_last_op == OP_RD);
  assign w_do_rd = !i_rst && r_ok && (!w_ok || r_last_op == OP_WR);

  // Round-robin scan over a doubled request vector avoids a modulo index.
  assign w_vv = {i_wr_valid, i_wr_valid};
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (!w_found && w_vv[w_idx]) begin
        w_found = 1'b1;
        w_sel   = (w_idx >= (PW+1)'(NUM_REQ)) ? PW'(w_idx - (PW+1)'(NUM_REQ)) : PW'(w_idx);
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign w_lane_sel[g] = w_do_wr && (w_sel == PW'(g));
      fifo_port_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .i_sel   (w_lane_sel[g]),
        .i_data  (i_wr_data[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_grant (o_wr_grant[g]),
        .o_data  (w_lane_data[g])
      );
    end
  endgenerate

  always_comb begin
    w_fifo_in = '0;
    for (int k = 0; k < NUM_REQ; k++) w_fifo_in = w_fifo_in | w_lane_data[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_op  <= OP_RD;
      r_rr_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_do_rd;
      if (w_do_rd) r_rd_data <= i_fifo_out;
      if (w_do_wr) begin
        r_last_op <= OP_WR;
        r_rr_ptr  <= (w_sel == PW'(NUM_REQ-1)) ? '0 : w_sel + PW'(1);
        r_count   <= r_count + CW'(1);
      end else if (w_do_rd) begin
        r_last_op <= OP_RD;
        r_count   <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(w_do_wr && r_count == CW'(SIZE)));
      assert (!(w_do_rd && r_count == '0));
      assert (!(w_do_wr && w_do_rd));
    end
  end

  assign o_fifo_en   = w_do_wr || w_do_rd;
  assign o_fifo_rw   = w_do_wr;
  assign o_fifo_addr = '0;
  assign o_fifo_in   = w_fifo_in;
  assign o_rd_grant  = w_do_rd;
  assign o_rd_data   = r_rd_data;
  // A reset arriving right after a pop drops the in-flight valid.
  assign o_rd_valid  = r_rd_valid && !i_rst;
  assign o_count     = r_count;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a behavioural fall-through FIFO.
module tb_fifo_port_arbiter;
  localparam int N = 4, DW = 4, SZ = 16, AW = 4, CW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      wr_valid;
  logic [N*DW-1:0]   wr_data;
  logic [N-1:0]      wr_grant;
  logic              rd_req, rd_grant, rd_valid;
  logic [DW-1:0]     rd_data;
  logic              fifo_en, fifo_rw, fifo_empty, fifo_full;
  logic [AW-1:0]     fifo_addr;
  logic [DW-1:0]     fifo_in, fifo_out;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
    .o_wr_grant(wr_grant), .i_rd_req(rd_req), .o_rd_grant(rd_grant),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_fifo_en(fifo_en),
    .o_fifo_rw(fifo_rw), .o_fifo_addr(fifo_addr), .o_fifo_in(fifo_in),
    .i_fifo_out(fifo_out), .i_fifo_empty(fifo_empty), .i_fifo_full(fifo_full),
    .o_count(count)
  );

  // Fall-through FIFO model: head is visible combinationally.
  logic [DW-1:0] mem [SZ];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] fcnt;
  assign fifo_out   = mem[rp];
  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt == CW'(SZ));
  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; fcnt <= '0;
    end else if (fifo_en) begin
      if (fifo_rw) begin
        mem[wp] <= fifo_in; wp <= wp + 1'b1; fcnt <= fcnt + 1'b1;
      end else begin
        rp <= rp + 1'b1; fcnt <= fcnt - 1'b1;
      end
    end
  end

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = '0; rd_req = 1'b0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  logic [N-1:0] g_exp [5];

  initial begin
    g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with every request asserted
    rst = 1'b1; wr_valid = '1; rd_req = 1'b1; wr_data = 16'h4321;
    tick();
    chk("rst_en", fifo_en, 0);
    chk("rst_wgnt", wr_grant, 0);
    chk("rst_rgnt", rd_grant, 0);
    chk("rst_cnt", count, 0);
    chk("rst_rvld", rd_valid, 0);
    chk("rst_rdat", rd_data, 0);
    tick();
    chk("rst2_en", fifo_en, 0);
    chk("rst2_cnt", count, 0);

    // Round-robin including pointer wrap
    rst = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("rr_gnt", wr_grant, g_exp[i]);
      chk("rr_din", fifo_in, (i % 4) + 1);
      chk("rr_rw", fifo_rw, 1);
      tick();
    end
    chk("rr_cnt", count, 5);
    chk("addr0", fifo_addr, 0);

    // Alternation: preload 5,1,2,3 then pop 5 so the last op is a read
    do_reset();
    wr_valid = 4'b0001;
    wr_data[3:0] = 4'd5; tick();
    wr_data[3:0] = 4'd1; tick();
    wr_data[3:0] = 4'd2; tick();
    wr_data[3:0] = 4'd3; tick();
    chk("alt_fill", count, 4);
    wr_valid = '0; rd_req = 1'b1;
    settle(); chk("alt_pre_rg", rd_grant, 1);
    tick();
    chk("alt_pre_rv", rd_valid, 1);
    chk("alt_pre_rd", rd_data, 5);
    chk("alt_pre_c", count, 3);
    wr_valid = 4'b0100; wr_data[11:8] = 4'd9;
    settle(); chk("altA_wg", wr_grant, 4'b0100); chk("altA_rg", rd_grant, 0);
    tick(); chk("altA_c", count, 4); chk("altA_rv", rd_valid, 0);
    settle(); chk("altB_rg", rd_grant, 1); chk("altB_wg", wr_grant, 0);
    tick(); chk("altB_rv", rd_valid, 1); chk("altB_rd", rd_data, 1); chk("altB_c", count, 3);
    settle(); chk("altC_wg", wr_grant, 4'b0100); chk("altC_rg", rd_grant, 0);
    tick(); chk("altC_rv", rd_valid, 0); chk("altC_rd", rd_data, 1); chk("altC_c", count, 4);
    settle(); chk("altD_rg", rd_grant, 1);
    tick(); chk("altD_rv", rd_valid, 1); chk("altD_rd", rd_data, 2); chk("altD_c", count, 3);
    wr_valid = '0; rd_req = 1'b0;

    // Full: writer 1 fills 16 words (data 3,4,...)
    do_reset();
    wr_valid = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      wr_data[7:4] = 4'(k + 3);
      tick();
    end
    chk("full_cnt", count, 16);
    settle(); chk("full_wg", wr_grant, 0); chk("full_en", fifo_en, 0);
    tick(); chk("full_hold", count, 16);
    rd_req = 1'b1;
    settle(); chk("full_rg", rd_grant, 1); chk("full_wg2", wr_grant, 0);
    tick(); rd_req = 1'b0;
    chk("full_c15", count, 15); chk("full_rv", rd_valid, 1); chk("full_rd", rd_data, 3);
    settle(); chk("full_rewr", wr_grant, 4'b0010);
    tick(); chk("full_c16", count, 16);
    wr_valid = '0;

    // Empty: reads blocked, then write 7 and read it back
    do_reset();
    rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle(); chk("emp_rg", rd_grant, 0);
      tick(); chk("emp_rv", rd_valid, 0);
    end
    wr_valid = 4'b0010; wr_data[7:4] = 4'd7;
    settle(); chk("emp_wg", wr_grant, 4'b0010); chk("emp_rg2", rd_grant, 0);
    tick(); wr_valid = '0;
    settle(); chk("emp_rg3", rd_grant, 1);
    tick(); rd_req = 1'b0;
    chk("emp_rv2", rd_valid, 1); chk("emp_rd", rd_data, 7); chk("emp_c", count, 0);

    // Reset right after a pop; pointer moved to 2 beforehand
    do_reset();
    wr_valid = 4'b0010; wr_data[7:4] = 4'd6;
    tick();
    wr_valid = '0; rd_req = 1'b1;
    settle(); chk("mr_rg", rd_grant, 1);
    tick();
    rst = 1'b1; rd_req = 1'b0;
    settle(); chk("mr_rv0", rd_valid, 0);
    tick();
    chk("mr_rv1", rd_valid, 0); chk("mr_cnt", count, 0);
    rst = 1'b0; wr_valid = '1; rd_req = 1'b1; wr_data = 16'h4321;
    settle(); chk("mr_wg", wr_grant, 4'b0001); chk("mr_rw", fifo_rw, 1); chk("mr_rg2", rd_grant, 0);
    tick(); chk("mr_rv2", rd_valid, 0);
    settle(); chk("mr_alt_rg", rd_grant, 1); chk("mr_alt_wg", wr_grant, 0);
    tick(); chk("mr_alt_rd", rd_data, 1);
    settle(); chk("mr_alt_wg2", wr_grant, 4'b0010);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_port_arbiter.md
# fifo_port_arbiter

Scheduler that shares the single read/write port of one `syncFIFO` instance between `NUM_REQ` write requesters and one reader. Each cycle it issues at most one FIFO operation. Writers are picked round-robin, and reads and writes alternate under contention. The block sits directly in front of a `syncFIFO` built with `FALL_THROUGH=1` and drives all of that FIFO's control inputs. It also tracks occupancy and returns read data to the reader with a registered valid.

## Interface
- `NUM_REQ`, 4: number of write requesters (≥2).
- `DATA_WIDTH`, 4: data word width; matches the FIFO.
- `SIZE`, 16: FIFO depth (power of two); matches the FIFO.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  NUM_REQ  per-requester write request.
- `wr_data`  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_grant`  out  NUM_REQ  one-hot, combinational; the granted word is written this cycle.
- `rd_req`  in  1  reader requests one word.
- `rd_grant`  out  1  combinational; a pop occurs this cycle.
- `rd_data`  out  DATA_WIDTH  registered popped word.
- `rd_valid`  out  1  registered; high for 1 cycle, 1 cycle after `rd_grant`.
- `fifo_en`, `fifo_rw`  out  1  FIFO control; `rw`=1 writes, `rw`=0 reads.
- `fifo_addr`  out  $clog2(SIZE)  tied to 0.
- `fifo_in`  out  DATA_WIDTH  data of the granted writer; 0 when there is no write.
- `fifo_out`, `fifo_empty`, `fifo_full`  in  FIFO outputs.
- `count`  out  $clog2(SIZE)+1  registered occupancy, 0..SIZE.

## Operation
- **Write eligibility.** `w_ok = |wr_valid && !fifo_full`.
- **Read eligibility.** `r_ok = rd_req && !fifo_empty`.
- **Op select.**
  - If only `w_ok`: WRITE.
  - If only `r_ok`: READ.
  - If both: the opposite of `last_op`.
  - If neither: no op, and `fifo_en`=0.
- **`last_op` register.** Updates only on an issued op. Reset value is READ, so the first contended cycle writes.
- **Writer selection.** Round-robin from pointer `rr_ptr`. Pick the first i with `wr_valid[i]` scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - On a write, `rr_ptr` ← granted index + 1 (mod `NUM_REQ`).
  - Otherwise `rr_ptr` holds.
  - Reset value is 0.
- **Write outputs.** `wr_grant` is nonzero only when the op is WRITE. A requester holds `wr_valid` and its data until granted.
- **Read.** On a READ cycle, `rd_grant`=1, `fifo_en`=1, `fifo_rw`=0. `fifo_out` (the fall-through head) is registered into `rd_data` and `rd_valid`=1 on the next cycle. `rd_data` holds its value otherwise.
- **count.**
  - +1 on WRITE, −1 on READ; never both in one cycle.
  - Must equal FIFO occupancy.
  - A WRITE is never issued at `count==SIZE`, and a READ is never issued at `count==0`, even if the FIFO flags disagree. This is checked by assertion.

## Timing
- **Reset.** All registered state and outputs clear on the first rising edge with `rst`=1: `rr_ptr`=0, `last_op`=READ, `count`=0, `rd_valid`=0, `rd_data`=0.
  - During reset, the combinational outputs are forced inactive: `fifo_en`=0, `wr_grant`=0, `rd_grant`=0.
  - Reset mid-operation discards the pending `rd_valid`. The FIFO is reset by the same `rst`.
- **Grant latency.** 0 cycles; the grant is combinational from the current inputs and registered state.
- **Read data latency.** 1 cycle from `rd_grant` to `rd_valid`/`rd_data`.
- **Throughput.** At most one FIFO op per cycle.
- **Bounded service under continuous contention.** Each writer is served within 2·`NUM_REQ` cycles, and the reader within 2 cycles.
- **Full FIFO.** Writes are blocked (`wr_grant`=0) and reads proceed. After the pop, the next cycle may write.
- **Empty FIFO.** Reads are blocked and `rd_valid` stays 0.
- **Pointer wrap.** After index `NUM_REQ`−1 is granted, `rr_ptr` wraps to 0.

## Test plan
- **Reset.** Hold `rst` for 2 cycles with all requests high → `fifo_en`=0, `count`=0, `rd_valid`=0, `wr_grant`=0.
- **Round-robin.** With `NUM_REQ`=4, all `wr_valid`=1, `rd_req`=0, data i+1 → grants 0001, 0010, 0100, 1000, 0001; `count` reaches 5 after 5 cycles.
- **Alternation.** With FIFO holding 3 words (1, 2, 3), `rd_req`=1 and `wr_valid[2]`=1 continuously → ops go W, R, W, R.
  - `rd_data` returns 1 then 2, each with a one-cycle `rd_valid` one cycle after its grant.
  - `count` stays within 3..4.
- **Full.** Fill to 16 → `fifo_full`=1 and `wr_grant`=0 with `wr_valid` held. Assert `rd_req` for 1 cycle → one pop, `count`=15, and a write is granted the next cycle.
- **Empty.** Assert `rd_req`=1 with the FIFO empty for 4 cycles → `rd_grant`=0 and `rd_valid`=0. Then `wr_valid[1]`=1 with data 7 → write, then read, then `rd_data`=7.
- **Mid-operation reset.** Assert `rst` in the cycle after a `rd_grant` → `rd_valid` never asserts, `count`=0, and the next contended grant goes to writer 0 with op WRITE.
